// File: rtl/gpio_ctrl.sv
// GPIO controller: pin register file, input synchroniser, per-pin glitch filter, edge/level IRQs.
// Ports: bus write (waddr_i/data_i/sel_i/we_i), bus read (raddr_i/rd_i -> data_o, 1-cycle latency),
//        pins (gpio_in_i raw in, gpio_out_o/gpio_oe_o out), irq_o = |(IP & IE).
module gpio_ctrl #(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        waddr_i,
  input  logic [31:0]       data_i,
  input  logic [3:0]        sel_i,
  input  logic              we_i,
  input  logic [7:0]        raddr_i,
  input  logic              rd_i,
  output logic [31:0]       data_o,
  input  logic [GPIO_W-1:0] gpio_in_i,
  output logic [GPIO_W-1:0] gpio_out_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);

  localparam logic [7:0] ADDR_DIN  = 8'h00;
  localparam logic [7:0] ADDR_OPT  = 8'h04;
  localparam logic [7:0] ADDR_OEC  = 8'h08;
  localparam logic [7:0] ADDR_IE   = 8'h0C;
  localparam logic [7:0] ADDR_ITYP = 8'h10;
  localparam logic [7:0] ADDR_IPOL = 8'h14;
  localparam logic [7:0] ADDR_IP   = 8'h18;
  localparam logic [7:0] ADDR_SET  = 8'h1C;
  localparam logic [7:0] ADDR_CLR  = 8'h20;
  localparam logic [7:0] ADDR_TGL  = 8'h24;
  localparam logic [7:0] ADDR_FILT = 8'h28;

  // Register file
  logic [GPIO_W-1:0] r_opt;
  logic [GPIO_W-1:0] r_oec;
  logic [GPIO_W-1:0] r_ie;
  logic [GPIO_W-1:0] r_ityp;
  logic [GPIO_W-1:0] r_ipol;
  logic [GPIO_W-1:0] r_ip;
  logic [FILT_W-1:0] r_filt;
  logic [31:0]       r_rdata;

  // Input path
  logic [GPIO_W-1:0] r_sync [SYNC_STAGES];
  logic [GPIO_W-1:0] r_f;
  logic [GPIO_W-1:0] r_f_d;
  logic [FILT_W-1:0] r_cnt  [GPIO_W];

  // Write data after byte-enable masking
  logic [31:0]       w_mask32;
  logic [31:0]       w_wdat32;
  logic [GPIO_W-1:0] w_wm;
  logic [GPIO_W-1:0] w_wd;
  logic [FILT_W-1:0] w_fm;
  logic [FILT_W-1:0] w_fd;

  logic [GPIO_W-1:0] w_s;
  logic [GPIO_W-1:0] w_edge;
  logic [GPIO_W-1:0] w_lvl;
  logic [GPIO_W-1:0] w_evt;
  logic [GPIO_W-1:0] w_ip_set;
  logic [GPIO_W-1:0] w_ip_clr;
  logic [31:0]       w_rdata;

  always_comb begin
    w_mask32 = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
    w_wdat32 = data_i & w_mask32;
    w_wm     = w_mask32[GPIO_W-1:0];
    w_wd     = w_wdat32[GPIO_W-1:0];
    w_fm     = w_mask32[FILT_W-1:0];
    w_fd     = w_wdat32[FILT_W-1:0];
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Event sources: both computed for every pin, ITYP selects per pin
  assign w_edge   = (r_ipol & r_f & ~r_f_d) | (~r_ipol & ~r_f & r_f_d);
  assign w_lvl    = (r_ipol & r_f) | (~r_ipol & ~r_f);
  assign w_evt    = (r_ityp & w_edge) | (~r_ityp & w_lvl);
  assign w_ip_set = w_evt & r_ie;
  assign w_ip_clr = (we_i && (waddr_i == ADDR_IP)) ? w_wd : '0;

  // Synchroniser and glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      for (int i = 0; i < GPIO_W; i++) r_cnt[i] <= '0;
      r_f   <= '0;
      r_f_d <= '0;
    end else begin
      r_sync[0] <= gpio_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_f_d <= r_f;
      for (int i = 0; i < GPIO_W; i++) begin
        if (w_s[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if ((r_cnt[i] == r_filt) || (&r_cnt[i])) begin
          // All-ones covers a threshold lowered below a count in progress
          r_f[i]   <= w_s[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + FILT_W'(1);
        end
      end
    end
  end

  // Register writes and interrupt pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opt  <= '0;
      r_oec  <= '0;
      r_ie   <= '0;
      r_ityp <= '0;
      r_ipol <= '0;
      r_ip   <= '0;
      r_filt <= '0;
    end else begin
      if (we_i) begin
        case (waddr_i)
          ADDR_OPT:  r_opt  <= (r_opt & ~w_wm) | w_wd;
          ADDR_SET:  r_opt  <= r_opt | w_wd;
          ADDR_CLR:  r_opt  <= r_opt & ~w_wd;
          ADDR_TGL:  r_opt  <= r_opt ^ w_wd;
          ADDR_OEC:  r_oec  <= (r_oec & ~w_wm) | w_wd;
          ADDR_IE:   r_ie   <= (r_ie & ~w_wm) | w_wd;
          ADDR_ITYP: r_ityp <= (r_ityp & ~w_wm) | w_wd;
          ADDR_IPOL: r_ipol <= (r_ipol & ~w_wm) | w_wd;
          ADDR_FILT: r_filt <= (r_filt & ~w_fm) | w_fd;
          default:   ;
        endcase
      end
      // Set after clear: a new event beats a simultaneous W1C
      r_ip <= (r_ip & ~w_ip_clr) | w_ip_set;
    end
  end

  // Read mux; SET/CLR/TGL and unmapped addresses read 0
  always_comb begin
    w_rdata = '0;
    case (raddr_i)
      ADDR_DIN:  w_rdata[GPIO_W-1:0] = r_f;
      ADDR_OPT:  w_rdata[GPIO_W-1:0] = r_opt;
      ADDR_OEC:  w_rdata[GPIO_W-1:0] = r_oec;
      ADDR_IE:   w_rdata[GPIO_W-1:0] = r_ie;
      ADDR_ITYP: w_rdata[GPIO_W-1:0] = r_ityp;
      ADDR_IPOL: w_rdata[GPIO_W-1:0] = r_ipol;
      ADDR_IP:   w_rdata[GPIO_W-1:0] = r_ip;
      ADDR_FILT: w_rdata[FILT_W-1:0] = r_filt;
      default:   w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (rd_i) begin
      r_rdata <= w_rdata;
    end
  end

  assign data_o     = r_rdata;
  assign gpio_out_o = r_opt;
  assign gpio_oe_o  = r_oec;
  assign irq_o      = |(r_ip & r_ie);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register file, filter timing, edge/level IRQs, reset abort.
// Inputs are driven 1 ns after the rising edge and outputs sampled at the same point.
module tb_gpio_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  waddr_i;
  logic [31:0] data_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic [7:0]  raddr_i;
  logic        rd_i;
  logic [31:0] data_o;
  logic [31:0] gpio_in_i;
  logic [31:0] gpio_out_o;
  logic [31:0] gpio_oe_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  gpio_ctrl #(.GPIO_W(32), .SYNC_STAGES(2), .FILT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .waddr_i    (waddr_i),
    .data_i     (data_i),
    .sel_i      (sel_i),
    .we_i       (we_i),
    .raddr_i    (raddr_i),
    .rd_i       (rd_i),
    .data_o     (data_o),
    .gpio_in_i  (gpio_in_i),
    .gpio_out_o (gpio_out_o),
    .gpio_oe_o  (gpio_oe_o),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v, input logic [3:0] s);
    waddr_i = a; data_i = v; sel_i = s; we_i = 1'b1;
    step(1);
    we_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    raddr_i = a; rd_i = 1'b1;
    step(1);
    rd_i = 1'b0;
    v = data_o;
  endtask

  initial begin
    rst = 1'b1; waddr_i = '0; data_i = '0; sel_i = '0; we_i = 1'b0;
    raddr_i = '0; rd_i = 1'b0; gpio_in_i = '0;
    step(3);
    rst = 1'b0;

    // Reset state
    check("rst_out", gpio_out_o, 32'h0);
    check("rst_oe", gpio_oe_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_dout", data_o, 32'h0);
    for (int i = 0; i < 11; i++) begin
      rd(8'(i * 4), d);
      check($sformatf("rst_rd_%02h", i * 4), d, 32'h0);
    end

    // Output register arithmetic with byte enables
    wr(8'h04, 32'h0000_00F0, 4'hF);
    check("opt_wr", gpio_out_o, 32'h0000_00F0);
    wr(8'h1C, 32'h0000_000F, 4'hF);
    check("opt_set", gpio_out_o, 32'h0000_00FF);
    wr(8'h20, 32'h0000_0030, 4'hF);
    check("opt_clr", gpio_out_o, 32'h0000_00CF);
    wr(8'h24, 32'h0000_0101, 4'hF);
    check("opt_tgl", gpio_out_o, 32'h0000_01CE);
    rd(8'h04, d);
    check("opt_rd", d, 32'h0000_01CE);
    raddr_i = 8'h00;
    step(3);
    check("dout_hold", data_o, 32'h0000_01CE);
    wr(8'h04, 32'hFFFF_FFFF, 4'b0001);
    check("opt_sel", gpio_out_o, 32'h0000_01FF);
    wr(8'h24, 32'hFFFF_FFFF, 4'b0100);
    check("tgl_sel", gpio_out_o, 32'h00FF_01FF);
    wr(8'h20, 32'hFFFF_FFFF, 4'b0100);
    check("clr_sel", gpio_out_o, 32'h0000_01FF);
    rd(8'h1C, d);
    check("set_rd0", d, 32'h0);
    wr(8'h08, 32'hFFFF_FFFF, 4'b0010);
    check("oec_sel", gpio_oe_o, 32'h0000_FF00);
    wr(8'h40, 32'hFFFF_FFFF, 4'hF);
    rd(8'h40, d);
    check("unmapped_rd", d, 32'h0);
    check("unmapped_wr", gpio_out_o, 32'h0000_01FF);

    // Glitch filter, FILT=3
    wr(8'h28, 32'h0000_0003, 4'hF);
    rd(8'h28, d);
    check("filt_rd", d, 32'h0000_0003);
    gpio_in_i[0] = 1'b1;
    step(3);
    gpio_in_i[0] = 1'b0;
    step(10);
    rd(8'h00, d);
    check("filt_pulse", d, 32'h0);
    // Change after edge e0: F rises at edge e0+6
    gpio_in_i[0] = 1'b1;
    step(5);
    rd(8'h00, d);
    check("filt_early", d, 32'h0);
    rd(8'h00, d);
    check("filt_exact", d, 32'h1);
    step(3);
    gpio_in_i[0] = 1'b0;
    step(10);
    rd(8'h00, d);
    check("filt_fall", d, 32'h0);

    // Rising-edge IRQ on pin 0, FILT=0
    wr(8'h28, 32'h0, 4'hF);
    wr(8'h10, 32'h1, 4'hF);
    wr(8'h14, 32'h1, 4'hF);
    wr(8'h0C, 32'h1, 4'hF);
    check("irq_idle", {31'h0, irq_o}, 32'h0);
    gpio_in_i[0] = 1'b1;
    step(3);
    check("irq_k2", {31'h0, irq_o}, 32'h0);
    step(1);
    check("irq_k3", {31'h0, irq_o}, 32'h1);
    wr(8'h18, 32'h1, 4'hF);
    check("irq_w1c", {31'h0, irq_o}, 32'h0);
    step(5);
    check("irq_noreassert", {31'h0, irq_o}, 32'h0);
    rd(8'h18, d);
    check("ip_edge_clr", d, 32'h0);

    // Low-level IRQ on pin 5 (ITYP[5]=0, IPOL[5]=0 already)
    wr(8'h0C, 32'h20, 4'hF);
    wr(8'h10, 32'h0, 4'hF);
    wr(8'h14, 32'h0, 4'hF);
    rd(8'h18, d);
    check("ip_lvl", d, 32'h0000_0020);
    check("irq_lvl", {31'h0, irq_o}, 32'h1);
    wr(8'h18, 32'h20, 4'hF);
    rd(8'h18, d);
    check("ip_setwins", d, 32'h0000_0020);
    gpio_in_i[5] = 1'b1;
    step(5);
    wr(8'h0C, 32'h0, 4'hF);
    check("irq_masked", {31'h0, irq_o}, 32'h0);
    rd(8'h18, d);
    check("ip_kept", d, 32'h0000_0020);
    wr(8'h18, 32'h20, 4'b0010);
    rd(8'h18, d);
    check("ip_w1c_sel", d, 32'h0000_0020);
    wr(8'h18, 32'h20, 4'hF);
    rd(8'h18, d);
    check("ip_lvl_clr", d, 32'h0);

    // Reset in the middle of a long filter count
    wr(8'h28, 32'd200, 4'hF);
    gpio_in_i = 32'h0000_0008;
    step(20);
    rd(8'h00, d);
    check("din_midfilt", d, 32'h0000_0021);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    check("rst2_out", gpio_out_o, 32'h0);
    check("rst2_oe", gpio_oe_o, 32'h0);
    check("rst2_irq", {31'h0, irq_o}, 32'h0);
    check("rst2_dout", data_o, 32'h0);
    step(2);
    rd(8'h00, d);
    check("rst2_din_early", d, 32'h0);
    rd(8'h00, d);
    check("rst2_din", d, 32'h0000_0008);
    for (int i = 1; i < 11; i++) begin
      rd(8'(i * 4), d);
      check($sformatf("rst2_rd_%02h", i * 4), d, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
